// File: rtl/uart_tx_engine.sv
// uart_tx_engine: byte-wide transmit FIFO feeding an 8-bit UART serialiser.
// Frame: start bit, 8 data bits LSB first, optional parity, then 1 or 2 stop bits.
// Mode and rate are latched when a byte is popped, so they only change between frames.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state and honours
// mode bits 0 (parity enable) and 1 (odd parity).
module uart_tx_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int MIN_RATE   = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          uart_enable,
  input  logic [2:0]                    uart_mode,
  input  logic [15:0]                   uart_rate,
  input  logic                          tx_wr,
  input  logic [7:0]                    tx_data,
  output logic                          txd,
  output logic [$clog2(FIFO_DEPTH):0]   tx_count,
  output logic                          uart_busy,
  output logic [1:0]                    uart_error,
  output logic                          update_ok
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL       = CW'(FIFO_DEPTH);
  localparam logic [15:0]   MIN_RATE_L = 16'(MIN_RATE);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t        state;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [15:0]   rate_q;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    data_q;
  logic          two_stop_q;
  logic          stop2_q;
`ifdef UART_TX_PARITY_EN
  logic          par_en_q;
  logic          par_odd_q;
`else
  logic          unused_mode;
`endif

  logic push;
  logic pop;
  logic overflow;
  logic rate_ok;
  logic last_tick;
  logic stop_done;

  // Push/pop qualification and end-of-bit / end-of-frame detection
  always_comb begin
    push      = tx_wr && (tx_count != FULL);
    overflow  = tx_wr && (tx_count == FULL);
    rate_ok   = (uart_rate >= MIN_RATE_L);
    last_tick = (bit_cnt == '0);
    stop_done = (state == STOP) && last_tick && (!two_stop_q || stop2_q);
    pop       = uart_enable && (tx_count != '0) && ((state == IDLE) || stop_done);
  end

`ifndef UART_TX_PARITY_EN
  // Parity mode bits have no function without the parity feature
  always_comb unused_mode = ^uart_mode[1:0];
`endif

  // FIFO storage; pointer wrap relies on FIFO_DEPTH being a power of two
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= tx_data;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      tx_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      tx_count <= tx_count + CW'(push) - CW'(pop);
    end
  end

  // Frame sequencer with registered line, status and error outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      txd        <= 1'b1;
      uart_busy  <= 1'b0;
      update_ok  <= 1'b1;
      uart_error <= '0;
      rate_q     <= '0;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      data_q     <= '0;
      two_stop_q <= 1'b0;
      stop2_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
`endif
    end else begin
      uart_error <= {pop && !rate_ok, overflow};
      if (pop && rate_ok) begin
        state      <= START;
        txd        <= 1'b0;
        uart_busy  <= 1'b1;
        update_ok  <= 1'b0;
        data_q     <= mem[rd_ptr];
        rate_q     <= uart_rate;
        bit_cnt    <= uart_rate - 16'd1;
        two_stop_q <= uart_mode[2];
`ifdef UART_TX_PARITY_EN
        par_en_q   <= uart_mode[0];
        par_odd_q  <= uart_mode[1];
`endif
      end else if (pop || stop_done) begin
        // illegal-rate pops are dropped here as well as normal frame ends
        state     <= IDLE;
        txd       <= 1'b1;
        uart_busy <= 1'b0;
        update_ok <= 1'b1;
      end else if ((state != IDLE) && !last_tick) begin
        bit_cnt <= bit_cnt - 16'd1;
      end else begin
        case (state)
          START: begin
            state   <= DATA;
            txd     <= data_q[0];
            bit_idx <= '0;
            bit_cnt <= rate_q - 16'd1;
          end
          DATA: begin
            bit_cnt <= rate_q - 16'd1;
            if (bit_idx != 3'd7) begin
              bit_idx <= bit_idx + 3'd1;
              txd     <= data_q[bit_idx + 3'd1];
`ifdef UART_TX_PARITY_EN
            end else if (par_en_q) begin
              state <= PARITY;
              txd   <= (^data_q) ^ par_odd_q;
`endif
            end else begin
              state   <= STOP;
              txd     <= 1'b1;
              stop2_q <= 1'b0;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state   <= STOP;
            txd     <= 1'b1;
            stop2_q <= 1'b0;
            bit_cnt <= rate_q - 16'd1;
          end
`endif
          STOP: begin
            // only reached at the end of the first of two stop bits
            stop2_q <= 1'b1;
            bit_cnt <= rate_q - 16'd1;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed frame checks plus randomized traffic against a
// waveform-queue reference model of the transmitter.
module tb_uart_tx_engine;

  localparam int DEPTH = 4;
  localparam int MINR  = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_enable = 1'b0;
  logic [2:0]  uart_mode = 3'd0;
  logic [15:0] uart_rate = 16'd4;
  logic        tx_wr = 1'b0;
  logic [7:0]  tx_data = 8'd0;
  logic        txd;
  logic [2:0]  tx_count;
  logic        uart_busy;
  logic [1:0]  uart_error;
  logic        update_ok;

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  uart_tx_engine #(.FIFO_DEPTH(DEPTH), .MIN_RATE(MINR)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_enable(uart_enable),
    .uart_mode  (uart_mode),
    .uart_rate  (uart_rate),
    .tx_wr      (tx_wr),
    .tx_data    (tx_data),
    .txd        (txd),
    .tx_count   (tx_count),
    .uart_busy  (uart_busy),
    .uart_error (uart_error),
    .update_ok  (update_ok)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: FIFO of bytes and a queue of per-cycle line levels for the frame in flight
  byte unsigned mq[$];
  bit           wq[$];
  logic         exp_txd  = 1'b1;
  logic         exp_busy = 1'b0;
  logic         exp_upd  = 1'b1;
  logic [1:0]   exp_err  = 2'b00;

  function automatic void build_frame(input logic [7:0] b, input logic [2:0] m, input logic [15:0] r);
    int nstop;
`ifdef UART_TX_PARITY_EN
    bit par;
`endif
    nstop = m[2] ? 2 : 1;
    repeat (r) wq.push_back(1'b0);
    for (int i = 0; i < 8; i++) repeat (r) wq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    if (m[0]) begin
      par = (^b) ^ m[1];
      repeat (r) wq.push_back(par);
    end
`endif
    repeat (nstop * int'(r)) wq.push_back(1'b1);
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int pre;
    logic ov;
    logic badr;
    logic [7:0] b;
    if (!rst_n) begin
      mq.delete();
      wq.delete();
      exp_txd  = 1'b1;
      exp_busy = 1'b0;
      exp_upd  = 1'b1;
      exp_err  = 2'b00;
    end else begin
      pre  = mq.size();
      ov   = tx_wr && (pre == DEPTH);
      badr = 1'b0;
      if (wq.size() > 0) begin
        exp_txd  = wq.pop_front();
        exp_busy = 1'b1;
      end else if (uart_enable && pre > 0) begin
        b = mq.pop_front();
        if (uart_rate < MINR) begin
          badr     = 1'b1;
          exp_txd  = 1'b1;
          exp_busy = 1'b0;
        end else begin
          build_frame(b, uart_mode, uart_rate);
          exp_txd  = wq.pop_front();
          exp_busy = 1'b1;
        end
      end else begin
        exp_txd  = 1'b1;
        exp_busy = 1'b0;
      end
      if (tx_wr && pre < DEPTH) mq.push_back(tx_data);
      exp_upd = !exp_busy;
      exp_err = {badr, ov};
    end
  end

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      check("txd", txd, exp_txd);
      check("uart_busy", uart_busy, exp_busy);
      check("update_ok", update_ok, exp_upd);
      check("uart_error", uart_error, exp_err);
      check("tx_count", tx_count, mq.size());
    end
  end

  task automatic push(input logic [7:0] b);
    tx_wr   = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_wr   = 1'b0;
  endtask

  // Send 0xA5 at rate 4 and check the line mid-bit against a literal sequence
  task automatic frame_test(input logic [2:0] m, input logic [10:0] seq, input int nb, input int len);
    int n;
    int idx;
    int v;
    bit rec[$];
    uart_enable = 1'b1;
    uart_mode   = m;
    uart_rate   = 16'd4;
    push(8'hA5);
    @(negedge clk);
    n = 0;
    while (uart_busy && n < 200) begin
      rec.push_back(txd);
      n++;
      @(negedge clk);
    end
    check("frame_len", n, len);
    for (int k = 0; k < nb; k++) begin
      idx = 4 * k + 1;
      v = (idx < rec.size()) ? int'(rec[idx]) : -1;
      check($sformatf("frame_bit%0d", k), v, int'(seq[k]));
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin : main
    int n;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_busy", uart_busy, 0);
    check("rst_update_ok", update_ok, 1);
    check("rst_error", uart_error, 0);
    check("rst_count", tx_count, 0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // basic frame and parity variants
    frame_test(3'b000, 11'b01101001010, 10, 40);
`ifdef UART_TX_PARITY_EN
    frame_test(3'b001, 11'b10101001010, 11, 44);
    frame_test(3'b011, 11'b11101001010, 11, 44);
`endif

    // overflow with transmitter disabled, then back-to-back drain
    uart_enable = 1'b0;
    uart_mode   = 3'b000;
    uart_rate   = 16'd4;
    for (int i = 1; i <= 5; i++) push(8'(i));
    check("ovf_count", tx_count, 4);
    check("ovf_pulse", uart_error, 1);
    @(negedge clk);
    check("ovf_once", uart_error, 0);
    uart_enable = 1'b1;
    @(negedge clk);
    n = 0;
    while (uart_busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("b2b_busy_cycles", n, 160);

    // illegal rate drops the byte
    uart_rate = 16'd1;
    push(8'h55);
    @(negedge clk);
    check("badrate_err", uart_error, 2);
    check("badrate_busy", uart_busy, 0);
    check("badrate_txd", txd, 1);
    check("badrate_count", tx_count, 0);
    @(negedge clk);
    check("badrate_once", uart_error, 0);

    // rate change mid-frame only affects the next frame
    uart_rate = 16'd4;
    tx_wr   = 1'b1;
    tx_data = 8'h3C;
    @(negedge clk);
    tx_data = 8'hC3;
    @(negedge clk);
    tx_wr = 1'b0;
    n = 0;
    repeat (5) begin
      if (uart_busy) n++;
      @(negedge clk);
    end
    uart_rate = 16'd10;
    while (uart_busy && n < 400) begin
      n++;
      @(negedge clk);
    end
    check("ratechg_busy_cycles", n, 140);

    // asynchronous reset during data bit 3
    uart_rate = 16'd8;
    uart_mode = 3'b100;
    push(8'hFF);
    @(negedge clk);
    repeat (35) @(negedge clk);
    check("midrst_pre_busy", uart_busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_txd", txd, 1);
    check("midrst_busy", uart_busy, 0);
    check("midrst_update_ok", update_ok, 1);
    check("midrst_count", tx_count, 0);
    check("midrst_error", uart_error, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_count", tx_count, 0);
    check("postrst_update_ok", update_ok, 1);
    check("postrst_busy", uart_busy, 0);

    // randomized traffic
    uart_enable = 1'b1;
    uart_mode   = 3'b000;
    uart_rate   = 16'd3;
    for (int c = 0; c < 4000; c++) begin
      tx_wr   = ($urandom_range(0, 2) == 0);
      tx_data = 8'($urandom);
      if ($urandom_range(0, 60) == 0)
        uart_rate = ($urandom_range(0, 5) == 0) ? 16'd1 : 16'($urandom_range(2, 5));
      if ($urandom_range(0, 40) == 0) uart_mode = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 150) == 0) uart_enable = ~uart_enable;
      @(negedge clk);
    end
    tx_wr       = 1'b0;
    uart_enable = 1'b1;
    uart_rate   = 16'd3;
    n = 0;
    while ((uart_busy || tx_count != 0) && n < 2000) begin
      n++;
      @(negedge clk);
    end
    check("drain_done", int'(n < 2000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
